alu_share_arbiter: RTL and testbench

Shares one N-bit logic/arithmetic unit (AND, OR, XOR, ADD) between NumReq requesters using round-robin arbitration.
Each requester presents operands and an opcode under a valid/ready handshake. The block captures the winner's operands, computes one registered result, and returns it with the requester ID under a second valid/ready handshake.
It sits between the ALU datapath and the control blocks that issue ALU operations.

---
 rtl/alu_share_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared opcode and FSM state encodings for the shared-ALU arbiter.
package alu_share_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    ptr,
  input  logic              en,
  output logic [NumReq-1:0] grant,
  output logic [IdW-1:0]    idx
);

  logic           found;
  logic [IdW-1:0] cand;

  // Scan candidates in priority order starting at ptr; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdW'((32'(ptr) + off) % NumReq);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One AND/OR/XOR/ADD unit shared by NumReq requesters under round-robin grant.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned Width  = 4,
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NumReq-1:0]       req_valid,
  output logic [NumReq-1:0]       req_ready,
  input  logic [NumReq*Width-1:0] req_first,
  input  logic [NumReq*Width-1:0] req_second,
  input  logic [NumReq*2-1:0]     req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IdW-1:0]          rsp_id,
  output logic [Width-1:0]        rsp_result,
  output logic                    rsp_carry
);

  state_e              state_q, state_d;
  logic [IdW-1:0]      ptr_q;
  logic [Width-1:0]    a_q, b_q;
  logic [1:0]          op_q;
  logic [IdW-1:0]      id_q;

  logic                arb_en;
  logic                exec;
  logic                done;
  logic                accept;
  logic [NumReq-1:0]   grant;
  logic [IdW-1:0]      gidx;
  logic [Width-1:0]    sel_a, sel_b;
  logic [1:0]          sel_op;
  logic [Width:0]      alu_sum;
  logic [Width-1:0]    alu_res;
  logic                alu_carry;

  rr_arbiter #(
    .NumReq (NumReq),
    .IdW    (IdW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant),
    .idx   (gidx)
  );

  // Grant is the accept strobe; it is only ever non-zero in IDLE.
  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_a     = req_first[32'(gidx)*Width +: Width];
  assign sel_b     = req_second[32'(gidx)*Width +: Width];
  assign sel_op    = req_op[32'(gidx)*2 +: 2];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded controls; arbitration is masked while reset is asserted.
  always_comb begin
    arb_en = 1'b0;
    exec   = 1'b0;
    done   = 1'b0;
    case (state_q)
      IDLE:    arb_en = rst_n;
      EXEC:    exec   = 1'b1;
      RESP:    done   = rsp_ready;
      default: ;
    endcase
  end

  // ALU over the latched operands; ADD carries out through the extra sum bit.
  always_comb begin
    alu_sum   = {1'b0, a_q} + {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_ADD: begin
        alu_res   = alu_sum[Width-1:0];
        alu_carry = alu_sum[Width];
      end
      default: ;
    endcase
  end

  // Operand capture, pointer advance and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= sel_a;
        b_q   <= sel_b;
        op_q  <= sel_op;
        id_q  <= gidx;
        ptr_q <= (gidx == IdW'(NumReq - 1)) ? '0 : gidx + IdW'(1);
      end
      if (exec) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= id_q;
        rsp_result <= alu_res;
        rsp_carry  <= alu_carry;
      end else if (done) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter against a queue-based model.
module tb_alu_share_arbiter;

  localparam int unsigned Width  = 4;
  localparam int unsigned NumReq = 4;
  localparam int unsigned IdW    = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NumReq-1:0]       req_valid;
  logic [NumReq-1:0]       req_ready;
  logic [NumReq*Width-1:0] req_first;
  logic [NumReq*Width-1:0] req_second;
  logic [NumReq*2-1:0]     req_op;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IdW-1:0]          rsp_id;
  logic [Width-1:0]        rsp_result;
  logic                    rsp_carry;

  logic [3:0] a_v [4];
  logic [3:0] b_v [4];
  logic [1:0] op_v[4];

  int errors = 0;
  int checks = 0;

  // Requester priority list: front is highest priority.
  int order[$];

  alu_share_arbiter #(
    .Width  (Width),
    .NumReq (NumReq),
    .IdW    (IdW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_first  (req_first),
    .req_second (req_second),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_first[i*4 +: 4]  = a_v[i];
      req_second[i*4 +: 4] = b_v[i];
      req_op[i*2 +: 2]     = op_v[i];
    end
  end

  task automatic mdl_reset();
    order = {0, 1, 2, 3};
  endtask

  function automatic int mdl_pick(logic [3:0] vld);
    for (int i = 0; i < order.size(); i++)
      if (vld[order[i]]) return order[i];
    return -1;
  endfunction

  // Served requester and everyone ahead of it drop to the back of the list.
  task automatic mdl_commit(int k);
    int guard = 0;
    while (order[0] != k && guard < 8) begin
      order.push_back(order.pop_front());
      guard++;
    end
    order.push_back(order.pop_front());
  endtask

  // Returns {carry, result} computed with plain integer arithmetic.
  function automatic logic [4:0] mdl_alu(logic [1:0] op, logic [3:0] a, logic [3:0] b);
    int s;
    case (op)
      2'd0:    s = int'(a & b);
      2'd1:    s = int'(a | b);
      2'd2:    s = int'(a ^ b);
      default: s = int'(a) + int'(b);
    endcase
    return 5'(s);
  endfunction

  function automatic logic [3:0] onehot(int k);
    logic [3:0] one = 4'd1;
    return (k < 0) ? 4'd0 : (one << k);
  endfunction

  task automatic randomize_payload();
    for (int i = 0; i < 4; i++) begin
      a_v[i]  = 4'($urandom);
      b_v[i]  = 4'($urandom);
      op_v[i] = 2'($urandom);
    end
  endtask

  // Drives one request vector from a negedge and collects the response.
  task automatic issue(input logic [3:0] vld, input bit hold,
                       output logic [3:0] gnt, output int lat,
                       output logic [1:0] id, output logic [3:0] res, output logic c);
    rsp_ready = !hold;
    req_valid = vld;
    #1 gnt = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    id  = rsp_id;
    res = rsp_result;
    c   = rsp_carry;
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mdl_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] g; int lat; logic [1:0] id; logic [3:0] r; logic c;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'($urandom);
      rsp_ready = 1'($urandom);
      randomize_payload();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'd0 || rsp_valid !== 1'b0 || rsp_result !== 4'd0 ||
          rsp_id !== 2'd0 || rsp_carry !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b valid=%b result=%h id=%0d carry=%b expected all zero",
                 req_ready, rsp_valid, rsp_result, rsp_id, rsp_carry);
      end
    end
    req_valid = '0;
    rst_n = 1'b1;
    mdl_reset();
    @(negedge clk);
    a_v[0] = 4'h9; b_v[0] = 4'h8; op_v[0] = 2'b11;
    issue(4'b0001, 1'b0, g, lat, id, r, c);
    mdl_commit(0);
    checks++;
    if (g !== 4'b0001) begin
      errors++; $display("FAIL first_grant: got %b expected 0001", g);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL first_latency: got %0d expected 2", lat);
    end
    checks++;
    if (r !== 4'h1 || c !== 1'b1 || id !== 2'd0) begin
      errors++;
      $display("FAIL first_add: result=%h carry=%b id=%0d expected 1 1 0", r, c, id);
    end
  endtask

  task automatic test_ops();
    logic [3:0] g; int lat; logic [1:0] id; logic [3:0] r; logic c;
    logic [3:0] exp_res [3];
    exp_res = '{4'h8, 4'hE, 4'h6};
    for (int k = 0; k < 3; k++) begin
      a_v[2] = 4'hC; b_v[2] = 4'hA; op_v[2] = 2'(k);
      issue(4'b0100, 1'b0, g, lat, id, r, c);
      mdl_commit(2);
      checks++;
      if (g !== 4'b0100 || lat !== 2 || r !== exp_res[k] || c !== 1'b0 || id !== 2'd2) begin
        errors++;
        $display("FAIL logic_op%0d: gnt=%b lat=%0d result=%h carry=%b id=%0d expected 0100 2 %h 0 2",
                 k, g, lat, r, c, id, exp_res[k]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] g; int lat; logic [1:0] id; logic [3:0] r; logic c;
    logic [4:0] e;
    pulse_reset();
    for (int t = 0; t < 8; t++) begin
      randomize_payload();
      e = mdl_alu(op_v[t % 4], a_v[t % 4], b_v[t % 4]);
      issue(4'b1111, 1'b0, g, lat, id, r, c);
      mdl_commit(t % 4);
      checks++;
      if (g !== onehot(t % 4) || id !== 2'(t % 4) || lat !== 2 || {c, r} !== e) begin
        errors++;
        $display("FAIL fairness_%0d: gnt=%b id=%0d lat=%0d cr=%h expected %b %0d 2 %h",
                 t, g, id, lat, {c, r}, onehot(t % 4), t % 4, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] g; int lat; logic [1:0] id; logic [3:0] r; logic c;
    int exp_k [2];
    exp_k = '{1, 3};
    for (int t = 0; t < 2; t++) begin
      randomize_payload();
      issue(4'b1010, 1'b0, g, lat, id, r, c);
      checks++;
      if (g !== onehot(exp_k[t]) || id !== 2'(exp_k[t]) ||
          g !== onehot(mdl_pick(4'b1010))) begin
        errors++;
        $display("FAIL wrap_%0d: gnt=%b id=%0d expected %b", t, g, id, onehot(exp_k[t]));
      end
      mdl_commit(exp_k[t]);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] g; int lat; logic [1:0] id; logic [3:0] r; logic c;
    logic [4:0] e;
    int k;
    randomize_payload();
    k = mdl_pick(4'b0100);
    e = mdl_alu(op_v[2], a_v[2], b_v[2]);
    issue(4'b0100, 1'b1, g, lat, id, r, c);
    mdl_commit(k);
    checks++;
    if (g !== 4'b0100 || lat !== 2 || {c, r} !== e || id !== 2'd2) begin
      errors++;
      $display("FAIL bp_capture: gnt=%b lat=%0d cr=%h id=%0d expected 0100 2 %h 2", g, lat, {c, r}, id, e);
    end
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_carry, rsp_result} !== e || rsp_id !== 2'd2 ||
          req_ready !== 4'd0) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid=%b cr=%h id=%0d ready=%b expected 1 %h 2 0000",
                 i, rsp_valid, {rsp_carry, rsp_result}, rsp_id, req_ready, e);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== onehot(mdl_pick(4'b1111))) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0 %b",
               rsp_valid, req_ready, onehot(mdl_pick(4'b1111)));
    end
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'd0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_before_grant: ready=%b valid=%b expected 0000 0", req_ready, rsp_valid);
    end
    randomize_payload();
    k = mdl_pick(4'b1111);
    issue(4'b1111, 1'b0, g, lat, id, r, c);
    mdl_commit(k);
    checks++;
    if (g !== onehot(k) || id !== 2'(k)) begin
      errors++;
      $display("FAIL bp_next_grant: gnt=%b id=%0d expected %b", g, id, onehot(k));
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] g; int lat; logic [1:0] id; logic [3:0] r; logic c;
    randomize_payload();
    a_v[1] = 4'hF; b_v[1] = 4'h3; op_v[1] = 2'b01;
    issue(4'b0010, 1'b1, g, lat, id, r, c);
    checks++;
    if (rsp_valid !== 1'b1 || r !== 4'hF) begin
      errors++; $display("FAIL rmid_pending: valid=%b result=%h expected 1 f", rsp_valid, r);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_result !== 4'd0 || rsp_id !== 2'd0 || req_ready !== 4'd0) begin
      errors++;
      $display("FAIL rmid_async: valid=%b result=%h id=%0d ready=%b expected 0 0 0 0000",
               rsp_valid, rsp_result, rsp_id, req_ready);
    end
    #1 rst_n = 1'b1;
    mdl_reset();
    @(negedge clk);
    randomize_payload();
    issue(4'b1111, 1'b0, g, lat, id, r, c);
    mdl_commit(0);
    checks++;
    if (g !== 4'b0001 || id !== 2'd0) begin
      errors++; $display("FAIL rmid_first: gnt=%b id=%0d expected 0001 0", g, id);
    end
  endtask

  task automatic test_random();
    logic [3:0] g; int lat; logic [1:0] id; logic [3:0] r; logic c;
    logic [3:0] vld;
    logic [4:0] e;
    int k;
    for (int t = 0; t < 40; t++) begin
      randomize_payload();
      vld = 4'($urandom_range(1, 15));
      k = mdl_pick(vld);
      e = mdl_alu(op_v[k], a_v[k], b_v[k]);
      issue(vld, 1'b0, g, lat, id, r, c);
      mdl_commit(k);
      checks++;
      if (g !== onehot(k) || lat !== 2 || id !== 2'(k) || {c, r} !== e || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: vld=%b gnt=%b lat=%0d id=%0d cr=%h valid_after=%b expected %b 2 %0d %h 0",
                 t, vld, g, lat, id, {c, r}, rsp_valid, onehot(k), k, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = '0; b_v[i] = '0; op_v[i] = '0;
    end
    mdl_reset();
    @(negedge clk);
    test_reset();
    test_ops();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
